// File: rtl/cpu_pkg.sv
// Shared encodings for the basic CPU: controller states, T-slot landmarks and
// opcode indices used by the timing and control blocks.
package cpu_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [3:0] T_FETCH_AR = 4'd0;
  localparam logic [3:0] T_FETCH_IR = 4'd2;
  localparam logic [3:0] T_ADDR     = 4'd4;
  localparam logic [3:0] T_EXEC_R   = 4'd6;
  localparam logic [3:0] T_MEM      = 4'd8;
  localparam logic [3:0] T_ALU      = 4'd10;

  localparam int OP_REGIO = 7;

endpackage

// File: rtl/onehot_dec.sv
// Generic IN_W-to-2^IN_W one-hot decoder; output is all-zero when en is low.
module onehot_dec #(
  parameter int IN_W = 4
) (
  input  logic                     en,
  input  logic [IN_W-1:0]          sel,
  output logic [(1 << IN_W)-1:0]   y
);

  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/timing_seq.sv
// Sequence counter, opcode latch and run/halt control for the basic CPU;
// emits the one-hot T-slot vector and registered opcode one-hot.
module timing_seq
  import cpu_pkg::*;
#(
  parameter int RREF_LAST   = 7,
  parameter int MREF_LAST   = 11,
  parameter int DEC_LATCH_T = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [15:0]      ir_odat,
  output logic [15:0]      dec_signal,
  output logic [7:0]       dec,
  output logic [3:0]       sc,
  output logic             running,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_cnt
);

  logic [1:0]       state_p0;
  logic [3:0]       sc_p0;
  logic [7:0]       dec_p0;
  logic [CNT_W-1:0] cnt_p0;

  logic [7:0] op_onehot;
  logic [3:0] last_slot;
  logic       at_last;
  logic       is_hlt;
  logic       unused_ir;

  assign unused_ir = ^ir_odat[11:1];

  // Before the opcode latch dec is zero, so early slots take the longer
  // memory-reference limit; no end check can fire before the latch anyway.
  assign last_slot  = dec_p0[OP_REGIO] ? 4'(RREF_LAST) : 4'(MREF_LAST);
  assign at_last    = (sc_p0 == last_slot);
  assign is_hlt     = dec_p0[OP_REGIO] && !ir_odat[15] && ir_odat[0];

  assign running    = (state_p0 == ST_RUN);
  assign instr_done = running && at_last;
  assign sc         = sc_p0;
  assign dec        = dec_p0;
  assign instr_cnt  = cnt_p0;

  onehot_dec #(.IN_W(3)) u_op_dec (
    .en  (1'b1),
    .sel (ir_odat[14:12]),
    .y   (op_onehot)
  );

  onehot_dec #(.IN_W(4)) u_slot_dec (
    .en  (running),
    .sel (sc_p0),
    .y   (dec_signal)
  );

  // Stage p0: controller state, slot counter, opcode latch, completion count
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= ST_IDLE;
      sc_p0    <= T_FETCH_AR;
      dec_p0   <= '0;
      cnt_p0   <= '0;
    end else begin
      case (state_p0)
        ST_RUN: begin
          if (at_last) begin
            cnt_p0   <= cnt_p0 + 1'b1;
            sc_p0    <= T_FETCH_AR;
            dec_p0   <= '0;
            state_p0 <= is_hlt ? ST_HALT : ST_RUN;
          end else begin
            sc_p0 <= (sc_p0 == 4'hF) ? T_FETCH_AR : sc_p0 + 4'd1;
            if (sc_p0 == 4'(DEC_LATCH_T)) dec_p0 <= op_onehot;
          end
        end
        ST_IDLE, ST_HALT: begin
          sc_p0  <= T_FETCH_AR;
          dec_p0 <= '0;
          if (run) state_p0 <= ST_RUN;
        end
        default: begin
          state_p0 <= ST_IDLE;
          sc_p0    <= T_FETCH_AR;
          dec_p0   <= '0;
        end
      endcase
    end
  end

endmodule
